// File: rtl/maze_pkg.sv
// Shared types and wall-vector index helpers for the maze renderer.
package maze_pkg;

   localparam int MAZE_N = 5;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_E = 2'd1,
      DIR_S = 2'd2,
      DIR_W = 2'd3
   } dir_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UPDATE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic valid;
      logic isRot;
      logic rotDir;
   } req_t;

   // North wall of cell (x,y); row MAZE_N is the southern border.
   function automatic logic [4:0] horWallIdx(input logic [2:0] x, input logic [2:0] y);
      return 5'(y) * 5'(MAZE_N) + 5'(x);
   endfunction

   // West wall of cell (x,y); column MAZE_N is the eastern border.
   function automatic logic [4:0] verWallIdx(input logic [2:0] x, input logic [2:0] y);
      return 5'(y) * 5'(MAZE_N + 1) + 5'(x);
   endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order pixel coordinate sweep that advances one step per enable.
module raster_counter
   import maze_pkg::*;
#(
   parameter int H_RES   = 800,
   parameter int V_RES   = 600,
   parameter int COORD_W = 12
)(
   input  logic               clk_in,
   input  logic               reset_btn,
   input  logic               i_en,
   output logic [COORD_W-1:0] o_px,
   output logic [COORD_W-1:0] o_py,
   output logic               o_last
);

   localparam logic [COORD_W-1:0] PX_MAX = COORD_W'(H_RES - 1);
   localparam logic [COORD_W-1:0] PY_MAX = COORD_W'(V_RES - 1);

   logic [COORD_W-1:0] r_px;
   logic [COORD_W-1:0] r_py;

   always_ff @(posedge clk_in or posedge reset_btn) begin
      if (reset_btn) begin
         r_px <= '0;
         r_py <= '0;
      end else if (i_en) begin
         if (r_px == PX_MAX) begin
            r_px <= '0;
            r_py <= (r_py == PY_MAX) ? '0 : r_py + 1'b1;
         end else begin
            r_px <= r_px + 1'b1;
         end
      end
   end

   assign o_px   = r_px;
   assign o_py   = r_py;
   assign o_last = (r_px == PX_MAX) && (r_py == PY_MAX);

endmodule

// File: rtl/maze_render_ctrl.sv
// Player pose update plus per-frame ray issue / pixel return sequencing
// into the framebuffer.
module maze_render_ctrl
   import maze_pkg::*;
#(
   parameter int H_RES   = 800,
   parameter int V_RES   = 600,
   parameter int COORD_W = 12
)(
   input  logic               clk_in,
   input  logic               reset_btn,
   input  logic               move_req,
   input  logic               rot_req,
   input  logic               rot_dir,
   input  logic [29:0]        hor_wall,
   input  logic [29:0]        ver_wall,
   output logic [2:0]         pos_x,
   output logic [2:0]         pos_y,
   output logic [1:0]         dir,
   output logic               ray_valid,
   input  logic               ray_ready,
   output logic [COORD_W-1:0] ray_px,
   output logic [COORD_W-1:0] ray_py,
   input  logic               pix_valid,
   output logic               pix_ready,
   input  logic [23:0]        pix_color,
   output logic               fb_we,
   output logic [18:0]        fb_addr,
   output logic [23:0]        fb_data,
   output logic               busy,
   output logic               frame_done,
   output logic               blocked,
   output logic [15:0]        frame_cnt
);

   localparam logic [18:0] PIX_TOTAL = 19'(H_RES * V_RES);
   localparam logic [2:0]  CELL_MAX  = 3'(MAZE_N - 1);

   state_t      r_state;
   req_t        r_pend;
   logic        r_curIsRot;
   logic        r_curRotDir;
   logic [2:0]  r_posX;
   logic [2:0]  r_posY;
   dir_t        r_dir;
   logic [18:0] r_retCnt;
   logic [15:0] r_frameCnt;
   logic        r_blocked;

   logic        w_rayFire;
   logic        w_rasterLast;
   logic        w_wallAhead;
   logic [2:0]  w_nextX;
   logic [2:0]  w_nextY;

   assign w_rayFire = ray_valid & ray_ready;

   raster_counter #(
      .H_RES   (H_RES),
      .V_RES   (V_RES),
      .COORD_W (COORD_W)
   ) u_issueCnt (
      .clk_in    (clk_in),
      .reset_btn (reset_btn),
      .i_en      (w_rayFire),
      .o_px      (ray_px),
      .o_py      (ray_py),
      .o_last    (w_rasterLast)
   );

   // Wall on the exit side of the current cell, and the clamped target cell.
   always_comb begin
      w_wallAhead = 1'b0;
      w_nextX     = r_posX;
      w_nextY     = r_posY;
      unique case (r_dir)
         DIR_N: begin
            w_wallAhead = hor_wall[horWallIdx(r_posX, r_posY)];
            if (r_posY != 3'd0) w_nextY = r_posY - 3'd1;
         end
         DIR_E: begin
            w_wallAhead = ver_wall[verWallIdx(r_posX + 3'd1, r_posY)];
            if (r_posX != CELL_MAX) w_nextX = r_posX + 3'd1;
         end
         DIR_S: begin
            w_wallAhead = hor_wall[horWallIdx(r_posX, r_posY + 3'd1)];
            if (r_posY != CELL_MAX) w_nextY = r_posY + 3'd1;
         end
         DIR_W: begin
            w_wallAhead = ver_wall[verWallIdx(r_posX, r_posY)];
            if (r_posX != 3'd0) w_nextX = r_posX - 3'd1;
         end
      endcase
   end

   // A fresh request written at the bottom overrides the IDLE-exit clear.
   always_ff @(posedge clk_in or posedge reset_btn) begin
      if (reset_btn) begin
         r_state     <= ST_ISSUE;
         r_pend      <= '0;
         r_curIsRot  <= 1'b0;
         r_curRotDir <= 1'b0;
         r_posX      <= 3'd0;
         r_posY      <= 3'd0;
         r_dir       <= DIR_E;
         r_retCnt    <= '0;
         r_frameCnt  <= '0;
         r_blocked   <= 1'b0;
      end else begin
         r_blocked <= 1'b0;
         if (fb_we) r_retCnt <= r_retCnt + 19'd1;
         unique case (r_state)
            ST_IDLE: begin
               if (r_pend.valid) begin
                  r_curIsRot   <= r_pend.isRot;
                  r_curRotDir  <= r_pend.rotDir;
                  r_pend.valid <= 1'b0;
                  r_state      <= ST_UPDATE;
               end
            end
            ST_UPDATE: begin
               if (r_curIsRot) begin
                  r_dir    <= r_curRotDir ? dir_t'(r_dir + 2'd1) : dir_t'(r_dir - 2'd1);
                  r_retCnt <= '0;
                  r_state  <= ST_ISSUE;
               end else if (w_wallAhead) begin
                  r_blocked <= 1'b1;
                  r_state   <= ST_IDLE;
               end else begin
                  r_posX   <= w_nextX;
                  r_posY   <= w_nextY;
                  r_retCnt <= '0;
                  r_state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (w_rayFire && w_rasterLast) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (r_retCnt == PIX_TOTAL) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_frameCnt <= r_frameCnt + 16'd1;
               r_retCnt   <= '0;
               r_state    <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         if (move_req ^ rot_req) r_pend <= '{valid: 1'b1, isRot: rot_req, rotDir: rot_dir};
      end
   end

   assign busy       = (r_state != ST_IDLE);
   assign ray_valid  = (r_state == ST_ISSUE);
   assign pix_ready  = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
   assign frame_done = (r_state == ST_DONE);
   assign blocked    = r_blocked;
   assign frame_cnt  = r_frameCnt;
   assign pos_x      = r_posX;
   assign pos_y      = r_posY;
   assign dir        = r_dir;
   assign fb_we      = pix_valid & pix_ready;
   assign fb_addr    = r_retCnt;
   assign fb_data    = pix_color;

endmodule

// File: tb/tb_maze_render_ctrl.sv
// Randomized bench for maze_render_ctrl on a reduced 8x4 raster with a
// 3-cycle pixel loopback and a cell-level pose/frame reference model.
module tb_maze_render_ctrl;

   localparam int H     = 8;
   localparam int V     = 4;
   localparam int TOTAL = H * V;

   logic        clk_in    = 1'b0;
   logic        reset_btn = 1'b1;
   logic        move_req  = 1'b0;
   logic        rot_req   = 1'b0;
   logic        rot_dir   = 1'b0;
   logic [29:0] hor_wall  = '0;
   logic [29:0] ver_wall  = '0;
   logic        ray_ready = 1'b0;
   logic        pix_valid = 1'b0;
   logic [23:0] pix_color = '0;

   logic [2:0]  pos_x, pos_y;
   logic [1:0]  dir;
   logic        ray_valid, pix_ready, fb_we, busy, frame_done, blocked;
   logic [11:0] ray_px, ray_py;
   logic [18:0] fb_addr;
   logic [23:0] fb_data;
   logic [15:0] frame_cnt;

   int total = 0;
   int bad   = 0;

   // reference pose / frame model
   int mX = 0, mY = 0, mDir = 1, mFrames = 0;

   // ray unit loopback state
   typedef struct {
      int          due;
      logic [23:0] color;
   } ret_t;
   ret_t q[$];
   int   cyc = 0, idx = 0, retIdx = 0, lastAddr = 0;
   int   frameWrites = -1, frameLastAddr = -1;
   bit   readyMode = 1'b0;
   bit   stalled = 1'b0;
   logic [23:0] heldXY = '0;

   maze_render_ctrl #(.H_RES(H), .V_RES(V), .COORD_W(12)) dut (
      .clk_in     (clk_in),
      .reset_btn  (reset_btn),
      .move_req   (move_req),
      .rot_req    (rot_req),
      .rot_dir    (rot_dir),
      .hor_wall   (hor_wall),
      .ver_wall   (ver_wall),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .dir        (dir),
      .ray_valid  (ray_valid),
      .ray_ready  (ray_ready),
      .ray_px     (ray_px),
      .ray_py     (ray_py),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_color  (pix_color),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .busy       (busy),
      .frame_done (frame_done),
      .blocked    (blocked),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk_in = ~clk_in;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [23:0] colorOf(input int x, input int y, input int f);
      return {8'(f), 8'(x), 8'(y)};
   endfunction

   // Ray unit: accepts rays, returns each shaded pixel three cycles later in
   // order, and checks every raster coordinate and framebuffer write.
   initial begin
      bit wantWrite;
      forever begin
         @(negedge clk_in);
         cyc++;
         if (reset_btn) begin
            q.delete();
            idx       = 0;
            retIdx    = 0;
            stalled   = 1'b0;
            pix_valid = 1'b0;
            ray_ready = 1'b0;
            continue;
         end
         wantWrite = 1'b0;
         pix_valid = 1'b0;
         if (q.size() > 0 && q[0].due <= cyc && pix_ready) begin
            pix_valid = 1'b1;
            pix_color = q[0].color;
            wantWrite = 1'b1;
            void'(q.pop_front());
         end
         if (stalled && ray_valid) checkOutput("stallHold", 32'({ray_px, ray_py}), 32'(heldXY));
         ray_ready = readyMode ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ray_valid && ray_ready) begin
            checkOutput("rayPx", 32'(ray_px), idx % H);
            checkOutput("rayPy", 32'(ray_py), idx / H);
            checkOutput("rayPose", {24'd0, 2'(dir), pos_x, pos_y}, {24'd0, 2'(mDir), 3'(mX), 3'(mY)});
            q.push_back('{due: cyc + 3, color: colorOf(int'(ray_px), int'(ray_py), mFrames)});
            idx++;
         end
         stalled = ray_valid && !ray_ready;
         heldXY  = {ray_px, ray_py};
         #1;
         checkOutput("fbWe", 32'(fb_we), 32'(wantWrite));
         if (wantWrite) begin
            checkOutput("fbAddr", 32'(fb_addr), retIdx);
            checkOutput("fbData", 32'(fb_data), 32'(colorOf(retIdx % H, retIdx / H, mFrames)));
            lastAddr = int'(fb_addr);
            retIdx++;
         end
         if (frame_done) begin
            frameWrites   = retIdx;
            frameLastAddr = lastAddr;
            idx           = 0;
            retIdx        = 0;
         end
      end
   end

   task automatic applyStimulus(input logic mv, input logic rt, input logic rd);
      move_req = mv;
      rot_req  = rt;
      rot_dir  = rd;
      @(negedge clk_in); #2;
      move_req = 1'b0;
      rot_req  = 1'b0;
   endtask

   task automatic waitFrame();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         @(negedge clk_in); #2;
         if (frame_done) seen = 1'b1;
      end
      if (!seen) begin
         checkOutput("frameTimeout", 32'(frame_done), 32'd1);
         return;
      end
      checkOutput("frameWrites", frameWrites, TOTAL);
      checkOutput("lastAddr", frameLastAddr, TOTAL - 1);
      mFrames++;
      @(negedge clk_in); #2;
      checkOutput("donePulse", 32'(frame_done), 32'd0);
      checkOutput("frameCnt", 32'(frame_cnt), mFrames);
      checkOutput("idleBusy", 32'(busy), 32'd0);
   endtask

   // Predict the outcome from cell/wall rules, apply the request, observe.
   task automatic runOp(input logic mv, input logic rt, input logic rd);
      bit expFrame, expBlk, wb;
      int blkSeen, raySeen, busySeen;
      expFrame = 1'b0; expBlk = 1'b0; wb = 1'b0;
      blkSeen = 0; raySeen = 0; busySeen = 0;
      if (mv && rt) begin
         expFrame = 1'b0;
      end else if (rt) begin
         mDir     = rd ? (mDir + 1) % 4 : (mDir + 3) % 4;
         expFrame = 1'b1;
      end else if (mv) begin
         case (mDir)
            0: wb = hor_wall[mY * 5 + mX];
            1: wb = ver_wall[mY * 6 + mX + 1];
            2: wb = hor_wall[(mY + 1) * 5 + mX];
            default: wb = ver_wall[mY * 6 + mX];
         endcase
         if (wb) begin
            expBlk = 1'b1;
         end else begin
            case (mDir)
               0: mY = (mY > 0) ? mY - 1 : 0;
               1: mX = (mX < 4) ? mX + 1 : 4;
               2: mY = (mY < 4) ? mY + 1 : 4;
               default: mX = (mX > 0) ? mX - 1 : 0;
            endcase
            expFrame = 1'b1;
         end
      end
      applyStimulus(mv, rt, rd);
      if (expFrame) begin
         waitFrame();
      end else begin
         repeat (8) begin
            @(negedge clk_in); #2;
            blkSeen  += int'(blocked);
            raySeen  += int'(ray_valid);
            busySeen += int'(busy);
         end
         checkOutput("blockedPulses", blkSeen, 32'(expBlk));
         checkOutput("noRay", raySeen, 0);
         if (!expBlk) checkOutput("ignoredBusy", busySeen, 0);
      end
      checkOutput("posX", 32'(pos_x), mX);
      checkOutput("posY", 32'(pos_y), mY);
      checkOutput("dir", 32'(dir), mDir);
      checkOutput("frameCntOp", 32'(frame_cnt), mFrames);
   endtask

   initial begin
      int op;
      repeat (3) @(negedge clk_in);
      #2;
      checkOutput("rstPosX", 32'(pos_x), 0);
      checkOutput("rstDir", 32'(dir), 1);
      checkOutput("rstFrameCnt", 32'(frame_cnt), 0);
      reset_btn = 1'b0;
      checkOutput("rstRayValid", 32'(ray_valid), 1);
      checkOutput("rstBusy", 32'(busy), 1);
      checkOutput("rstPixReady", 32'(pix_ready), 1);
      checkOutput("rstRayXY", 32'({ray_px, ray_py}), 0);
      checkOutput("rstPulses", 32'({frame_done, blocked}), 0);
      checkOutput("rstPosY", 32'(pos_y), 0);

      waitFrame();
      readyMode = 1'b1;

      ver_wall = 30'd2;
      runOp(1'b1, 1'b0, 1'b0);
      runOp(1'b1, 1'b1, 1'b0);
      runOp(1'b0, 1'b1, 1'b0);
      runOp(1'b0, 1'b1, 1'b0);
      checkOutput("rotLeftToW", 32'(dir), 3);

      for (int i = 0; i < 20; i++) begin
         hor_wall = 30'($urandom & $urandom);
         ver_wall = 30'($urandom & $urandom);
         op = int'($urandom_range(0, 3));
         case (op)
            0, 1: runOp(1'b1, 1'b0, 1'b0);
            2:    runOp(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            default: runOp(1'b1, 1'b1, 1'($urandom_range(0, 1)));
         endcase
      end

      // reset partway through a frame
      mDir = (mDir + 1) % 4;
      applyStimulus(1'b0, 1'b1, 1'b1);
      for (int n = 0; n < 2000 && idx < 10; n++) begin
         @(negedge clk_in); #2;
      end
      if (idx < 10) checkOutput("midFrameTimeout", 32'(ray_valid), 32'd0);
      reset_btn = 1'b1;
      #1;
      checkOutput("midRstPos", 32'({pos_x, pos_y}), 0);
      checkOutput("midRstDir", 32'(dir), 1);
      checkOutput("midRstFrameCnt", 32'(frame_cnt), 0);
      checkOutput("midRstRayXY", 32'({ray_px, ray_py}), 0);
      checkOutput("midRstPulses", 32'({frame_done, blocked}), 0);
      checkOutput("midRstBusy", 32'(busy), 1);
      mX = 0; mY = 0; mDir = 1; mFrames = 0;
      repeat (2) @(negedge clk_in);
      #2;
      reset_btn = 1'b0;
      waitFrame();
      runOp(1'b0, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/maze_render_ctrl.md
MAZE_RENDER_CTRL -- requirements
Module: maze_render_ctrl

Interface
REQ-001 Parameter H_RES, default 800, pixels per line swept per frame.
REQ-002 Parameter V_RES, default 600, lines swept per frame.
REQ-003 Parameter COORD_W, default 12, width of pixel coordinates.
REQ-004 clk_in  in  1  system clock; all logic rising-edge.
REQ-005 reset_btn  in  1  reset, asynchronous, active-high.
REQ-006 move_req  in  1  single-cycle request: step one cell forward.
REQ-007 rot_req  in  1  single-cycle request: rotate 90 degrees.
REQ-008 rot_dir  in  1  rotation sense, sampled with rot_req; 0 = left (dir-1), 1 = right (dir+1).
REQ-009 hor_wall  in  30  horizontal walls, 6 rows x 5; bit y*5+x is the wall on the north side of cell (x,y).
REQ-010 ver_wall  in  30  vertical walls, 5 rows x 6; bit y*6+x is the wall on the west side of cell (x,y).
REQ-011 pos_x, pos_y  out  3 each  player cell, range 0..4.
REQ-012 dir  out  2  heading: 0=N(y-1), 1=E(x+1), 2=S(y+1), 3=W(x-1).
REQ-013 ray_valid / ray_ready  out / in  1  issue handshake to ray unit; a transfer occurs when both are 1.
REQ-014 ray_px, ray_py  out  COORD_W  pixel coordinate of the issued ray.
REQ-015 pix_valid / pix_ready  in / out  1  in-order shaded-pixel return handshake.
REQ-016 pix_color  in  24  returned RGB value.
REQ-017 fb_we, fb_addr, fb_data  out  1, 19, 24  framebuffer write port.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 frame_done  out  1  one-cycle pulse when a frame completes.
REQ-020 blocked  out  1  one-cycle pulse when a move is rejected.
REQ-021 frame_cnt  out  16  completed frames, wraps at 65535 -> 0.

Function
REQ-022 FSM states: IDLE, UPDATE, ISSUE, DRAIN, DONE.
REQ-023 IDLE: a pending request -> UPDATE; otherwise hold.
REQ-024 UPDATE (1 cycle) applies the request; rotation or accepted move -> ISSUE; rejected move -> blocked pulse, then IDLE.
REQ-025 Move rejected when the wall on the exit side of the current cell is set; the outer border walls are checked the same way via the wall vectors; position clamped to 0..4 regardless of wall state.
REQ-026 move_req and rot_req high in the same cycle -> both ignored.
REQ-027 One pending-request register, written in any state; a newer request overwrites an older unserviced one; it is cleared on entry to UPDATE.
REQ-028 ISSUE: ray_px/ray_py sweep raster order from (0,0); they advance only on a ray transfer; px wraps at H_RES-1 -> 0 with py+1; after the transfer at (H_RES-1, V_RES-1) -> DRAIN.
REQ-029 ray_valid is 1 in ISSUE only; ray_px, ray_py, pos_x, pos_y and dir are stable while ray_valid=1 and ray_ready=0.
REQ-030 pix_ready is 1 in ISSUE and DRAIN, 0 otherwise.
REQ-031 fb_we = pix_valid & pix_ready, combinational; fb_data = pix_color; fb_addr = return counter, starting at 0 per frame and incrementing per accepted pixel.
REQ-032 DRAIN -> DONE when the return counter reaches H_RES*V_RES; DONE (1 cycle): frame_done=1, frame_cnt+1, then IDLE.
REQ-033 pos_x, pos_y and dir change only in UPDATE, so one frame never mixes two poses.
REQ-034 Issue and return counters are independent; returns can overlap issues with no outstanding limit beyond the ray_ready backpressure.

Reset
REQ-035 On reset: state ISSUE (automatic first frame), pos (0,0), dir=1 (E), counters and frame_cnt 0, pending cleared, pulses 0.
REQ-036 Reset mid-frame abandons all outstanding transactions; returns from before reset are not written after the first frame restarts.

Structure
REQ-037 Shared package maze_pkg: direction enum, FSM state enum, MAZE_N=5, wall-index helper functions.
REQ-038 Sub-module raster_counter (px/py sweep with enable and wrap) is used for the issue counter.

Verification
REQ-039 Reset, ray_ready=1, pix loopback at 3-cycle latency -> 480000 fb_we pulses, last fb_addr 479999, frame_done once, frame_cnt=1.
REQ-040 At (0,0) dir=E, ver_wall bit 1 set, move_req -> blocked pulse, pos stays (0,0), no ray_valid.
REQ-041 rot_req with rot_dir=0 from dir=0 -> dir=3, new frame rendered.
REQ-042 move_req and rot_req in the same cycle -> no state change, busy stays 0.
REQ-043 ray_ready toggled randomly mid-frame -> coordinates held during stalls, no skipped or duplicated (px,py).
REQ-044 reset_btn asserted at pixel 1000 -> outputs at reset values, frame restarts at (0,0), frame_cnt=0.
